// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB FSM with a 32x32 register file.
module multi_cycle_mips #(
  parameter int unsigned DM_AW    = 7,
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      IR_addr,
  input  logic [31:0]      IR,
  input  logic [31:0]      ReadDataMem,
  input  logic             MemReady,
  output logic             CEN,
  output logic             WEN,
  output logic             OEN,
  output logic [DM_AW-1:0] A,
  output logic [31:0]      Data2Mem,
  output logic             Illegal
);

  localparam logic [5:0] OpRtype = 6'h00, OpJ = 6'h02, OpJal = 6'h03, OpBeq = 6'h04;
  localparam logic [5:0] OpBne = 6'h05, OpAddi = 6'h08, OpLw = 6'h23, OpSw = 6'h2B;
  localparam logic [5:0] FnJr = 6'h08, FnAdd = 6'h20, FnSub = 6'h22, FnAnd = 6'h24;
  localparam logic [5:0] FnOr = 6'h25, FnSlt = 6'h2A;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [31:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic        illegal_q, illegal_d;
  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  op, funct;
  logic        is_rtype, r_alu, is_jr, is_lw, is_sw, is_beq, is_bne, is_addi, is_j, is_jal;
  logic [31:0] alu_b, alu_res, pc_plus4, branch_tgt, jump_tgt;
  logic        taken;

  // Instruction decode from the latched instruction register.
  always_comb begin
    op       = ir_q[31:26];
    funct    = ir_q[5:0];
    // Nonzero shamt is not a supported encoding for any R-type op here.
    is_rtype = (op == OpRtype) && (ir_q[10:6] == 5'd0);
    r_alu    = is_rtype && (funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt});
    is_jr    = is_rtype && (funct == FnJr);
    is_lw    = (op == OpLw);
    is_sw    = (op == OpSw);
    is_beq   = (op == OpBeq);
    is_bne   = (op == OpBne);
    is_addi  = (op == OpAddi);
    is_j     = (op == OpJ);
    is_jal   = (op == OpJal);
  end

  // ALU and PC target arithmetic, all modulo 2^32.
  always_comb begin
    alu_b   = (is_addi || is_lw || is_sw) ? imm_q : b_q;
    alu_res = a_q + alu_b;
    if (r_alu) begin
      case (funct)
        FnSub:   alu_res = a_q - b_q;
        FnAnd:   alu_res = a_q & b_q;
        FnOr:    alu_res = a_q | b_q;
        FnSlt:   alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
        default: alu_res = a_q + b_q;
      endcase
    end
    pc_plus4   = pc_q + 32'd4;
    branch_tgt = pc_plus4 + {imm_q[29:0], 2'b00};
    jump_tgt   = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    taken      = is_beq ? (a_q == b_q) : (a_q != b_q);
  end

  // Next-state logic for the FSM, datapath registers and register-file write port.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    rf_waddr  = 5'd0;
    rf_wdata  = 32'd0;
    unique case (state_q)
      StFetch: begin
        ir_d    = IR;
        state_d = StDecode;
      end
      StDecode: begin
        a_d     = rf_q[ir_q[25:21]];
        b_d     = rf_q[ir_q[20:16]];
        imm_d   = {{16{ir_q[15]}}, ir_q[15:0]};
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_plus4;
        if (r_alu || is_addi) begin
          alu_out_d = alu_res;
          pc_d      = pc_q;
          state_d   = StWb;
        end else if (is_lw || is_sw) begin
          alu_out_d = alu_res;
          pc_d      = pc_q;
          state_d   = StMem;
        end else if (is_beq || is_bne) begin
          pc_d = taken ? branch_tgt : pc_plus4;
        end else if (is_j || is_jal) begin
          pc_d = jump_tgt;
          if (is_jal) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_plus4;
          end
        end else if (is_jr) begin
          pc_d = a_q;
        end else begin
          // Unsupported encoding: flag it and fall through as a no-op.
          illegal_d = 1'b1;
        end
      end
      StMem: begin
        if (MemReady) begin
          if (is_lw) begin
            mdr_d   = ReadDataMem;
            state_d = StWb;
          end else begin
            pc_d    = pc_plus4;
            state_d = StFetch;
          end
        end
      end
      StWb: begin
        rf_we    = 1'b1;
        rf_waddr = r_alu ? ir_q[15:11] : ir_q[20:16];
        rf_wdata = is_lw ? mdr_q : alu_out_q;
        pc_d     = pc_plus4;
        state_d  = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      illegal_q <= illegal_d;
    end
  end

  // Register file; entry 0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Strobes are gated by rst_n so a reset in MEM kills the access without waiting for a clock.
  assign IR_addr  = pc_q;
  assign CEN      = ~((state_q == StMem) && rst_n);
  assign OEN      = ~((state_q == StMem) && is_lw && rst_n);
  assign WEN      = ~((state_q == StMem) && is_sw && rst_n);
  assign A        = alu_out_q[DM_AW+1:2];
  assign Data2Mem = b_q;
  assign Illegal  = illegal_q;

endmodule

// File: tb/tb_multi_cycle_mips.sv
// Directed bench for multi_cycle_mips; register contents are observed by storing them.
module tb_multi_cycle_mips;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IR_addr, IR, ReadDataMem, Data2Mem;
  logic        MemReady, CEN, WEN, OEN, Illegal;
  logic [6:0]  A;

  int total = 0;
  int bad   = 0;

  // Per-instruction observations gathered by run_instr.
  int          mem_cyc, wen_cyc, oen_cyc;
  logic        mem_stable;
  logic [6:0]  a_seen;
  logic [31:0] d_seen;

  multi_cycle_mips #(.DM_AW(7), .PC_RESET(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .IR_addr(IR_addr), .IR(IR), .ReadDataMem(ReadDataMem),
    .MemReady(MemReady), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
    .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Present one instruction for a fixed number of clocks (entered and left at a negedge
  // in FETCH) and act as a data memory answering after 'waits' MEM cycles.
  task automatic run_instr(input logic [31:0] instr, input int cycles, input int waits,
                           input logic [31:0] rdata);
    IR = instr;
    ReadDataMem = rdata;
    mem_cyc = 0; wen_cyc = 0; oen_cyc = 0; mem_stable = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if (CEN === 1'b0) begin
        if (mem_cyc == 0) begin
          a_seen = A;
          d_seen = Data2Mem;
        end else if (A !== a_seen || Data2Mem !== d_seen) begin
          mem_stable = 1'b0;
        end
        mem_cyc++;
        if (WEN === 1'b0) wen_cyc++;
        if (OEN === 1'b0) oen_cyc++;
        MemReady = (mem_cyc > waits);
      end else begin
        MemReady = 1'b0;
      end
      @(negedge clk);
    end
    MemReady = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; IR = '0; MemReady = 1'b0; ReadDataMem = '0;
    #2;
    total++; if (CEN !== 1'b1) begin bad++; $display("FAIL rst_cen got=%b exp=1", CEN); end
    total++; if (WEN !== 1'b1) begin bad++; $display("FAIL rst_wen got=%b exp=1", WEN); end
    total++; if (OEN !== 1'b1) begin bad++; $display("FAIL rst_oen got=%b exp=1", OEN); end
    total++; if (A !== 7'd0) begin bad++; $display("FAIL rst_a got=%h exp=0", A); end
    total++; if (Data2Mem !== 32'd0) begin bad++; $display("FAIL rst_d2m got=%h exp=0", Data2Mem); end
    total++; if (Illegal !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%b exp=0", Illegal); end
    @(negedge clk); @(negedge clk);
    total++; if (IR_addr !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", IR_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_alu_seq;
    run_instr(itype(6'h08, 5'd0, 5'd1, 16'd5), 4, 0, '0);
    total++; if (IR_addr !== 32'h4) begin bad++; $display("FAIL seq_pc1 got=%h exp=4", IR_addr); end
    run_instr(itype(6'h08, 5'd0, 5'd2, 16'd7), 4, 0, '0);
    total++; if (IR_addr !== 32'h8) begin bad++; $display("FAIL seq_pc2 got=%h exp=8", IR_addr); end
    run_instr(rtype(6'h20, 5'd1, 5'd2, 5'd3), 4, 0, '0);
    total++; if (IR_addr !== 32'hC) begin bad++; $display("FAIL seq_pc3 got=%h exp=c", IR_addr); end
    total++; if (mem_cyc !== 0) begin bad++; $display("FAIL seq_nomem got=%0d exp=0", mem_cyc); end
  endtask

  task automatic test_sw_wait;
    run_instr(itype(6'h2B, 5'd0, 5'd3, 16'd8), 7, 3, '0);
    total++; if (mem_cyc !== 4) begin bad++; $display("FAIL sw_cen_cycles got=%0d exp=4", mem_cyc); end
    total++; if (wen_cyc !== 4) begin bad++; $display("FAIL sw_wen_cycles got=%0d exp=4", wen_cyc); end
    total++; if (oen_cyc !== 0) begin bad++; $display("FAIL sw_oen_cycles got=%0d exp=0", oen_cyc); end
    total++; if (a_seen !== 7'd2) begin bad++; $display("FAIL sw_a got=%h exp=2", a_seen); end
    total++; if (d_seen !== 32'd12) begin bad++; $display("FAIL sw_data got=%h exp=c", d_seen); end
    total++; if (mem_stable !== 1'b1) begin bad++; $display("FAIL sw_stable got=%b exp=1", mem_stable); end
    total++; if (IR_addr !== 32'h10) begin bad++; $display("FAIL sw_pc got=%h exp=10", IR_addr); end
  endtask

  task automatic test_lw;
    run_instr(itype(6'h23, 5'd0, 5'd4, 16'd8), 5, 0, 32'hDEADBEEF);
    total++; if (oen_cyc !== 1) begin bad++; $display("FAIL lw_oen_cycles got=%0d exp=1", oen_cyc); end
    total++; if (wen_cyc !== 0) begin bad++; $display("FAIL lw_wen_cycles got=%0d exp=0", wen_cyc); end
    total++; if (IR_addr !== 32'h14) begin bad++; $display("FAIL lw_pc got=%h exp=14", IR_addr); end
    run_instr(itype(6'h2B, 5'd0, 5'd4, 16'd12), 4, 0, '0);
    total++; if (d_seen !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_reg got=%h exp=deadbeef", d_seen); end
    total++; if (a_seen !== 7'd3) begin bad++; $display("FAIL lw_sw_a got=%h exp=3", a_seen); end
    total++; if (IR_addr !== 32'h18) begin bad++; $display("FAIL lw_sw_pc got=%h exp=18", IR_addr); end
  endtask

  task automatic test_alu_ops;
    run_instr(rtype(6'h22, 5'd1, 5'd2, 5'd5), 4, 0, '0);
    run_instr(rtype(6'h2A, 5'd5, 5'd1, 5'd6), 4, 0, '0);
    run_instr(rtype(6'h24, 5'd1, 5'd2, 5'd7), 4, 0, '0);
    run_instr(rtype(6'h25, 5'd1, 5'd2, 5'd8), 4, 0, '0);
    run_instr(itype(6'h2B, 5'd0, 5'd5, 16'd0), 4, 0, '0);
    total++; if (d_seen !== 32'hFFFFFFFE) begin bad++; $display("FAIL sub got=%h exp=fffffffe", d_seen); end
    run_instr(itype(6'h2B, 5'd0, 5'd6, 16'd0), 4, 0, '0);
    total++; if (d_seen !== 32'd1) begin bad++; $display("FAIL slt got=%h exp=1", d_seen); end
    run_instr(itype(6'h2B, 5'd0, 5'd7, 16'd0), 4, 0, '0);
    total++; if (d_seen !== 32'd5) begin bad++; $display("FAIL and got=%h exp=5", d_seen); end
    run_instr(itype(6'h2B, 5'd0, 5'd8, 16'd0), 4, 0, '0);
    total++; if (d_seen !== 32'd7) begin bad++; $display("FAIL or got=%h exp=7", d_seen); end
    total++; if (IR_addr !== 32'h38) begin bad++; $display("FAIL ops_pc got=%h exp=38", IR_addr); end
  endtask

  task automatic test_branch;
    run_instr(jtype(6'h02, 26'h8), 3, 0, '0);
    total++; if (IR_addr !== 32'h20) begin bad++; $display("FAIL j_pc got=%h exp=20", IR_addr); end
    run_instr(itype(6'h04, 5'd1, 5'd1, 16'hFFFF), 3, 0, '0);
    total++; if (IR_addr !== 32'h20) begin bad++; $display("FAIL beq_taken got=%h exp=20", IR_addr); end
    run_instr(itype(6'h05, 5'd1, 5'd1, 16'hFFFF), 3, 0, '0);
    total++; if (IR_addr !== 32'h24) begin bad++; $display("FAIL bne_not got=%h exp=24", IR_addr); end
    run_instr(itype(6'h05, 5'd1, 5'd2, 16'd3), 3, 0, '0);
    total++; if (IR_addr !== 32'h34) begin bad++; $display("FAIL bne_taken got=%h exp=34", IR_addr); end
    run_instr(itype(6'h04, 5'd1, 5'd2, 16'd3), 3, 0, '0);
    total++; if (IR_addr !== 32'h38) begin bad++; $display("FAIL beq_not got=%h exp=38", IR_addr); end
  endtask

  task automatic test_jal_jr;
    run_instr(jtype(6'h02, 26'h10), 3, 0, '0);
    total++; if (IR_addr !== 32'h40) begin bad++; $display("FAIL j40_pc got=%h exp=40", IR_addr); end
    run_instr(jtype(6'h03, 26'h100), 3, 0, '0);
    total++; if (IR_addr !== 32'h400) begin bad++; $display("FAIL jal_pc got=%h exp=400", IR_addr); end
    run_instr(rtype(6'h08, 5'd31, 5'd0, 5'd0), 3, 0, '0);
    total++; if (IR_addr !== 32'h44) begin bad++; $display("FAIL jr_pc got=%h exp=44", IR_addr); end
    run_instr(itype(6'h2B, 5'd0, 5'd31, 16'd0), 4, 0, '0);
    total++; if (d_seen !== 32'h44) begin bad++; $display("FAIL jal_link got=%h exp=44", d_seen); end
  endtask

  task automatic test_illegal;
    total++; if (Illegal !== 1'b0) begin bad++; $display("FAIL ill_pre got=%b exp=0", Illegal); end
    run_instr({6'h3F, 26'h0}, 3, 0, '0);
    total++; if (Illegal !== 1'b1) begin bad++; $display("FAIL ill_op got=%b exp=1", Illegal); end
    total++; if (IR_addr !== 32'h4C) begin bad++; $display("FAIL ill_pc got=%h exp=4c", IR_addr); end
    total++; if (mem_cyc !== 0) begin bad++; $display("FAIL ill_mem got=%0d exp=0", mem_cyc); end
    run_instr(rtype(6'h3F, 5'd1, 5'd2, 5'd1), 3, 0, '0);
    total++; if (IR_addr !== 32'h50) begin bad++; $display("FAIL ill_fn_pc got=%h exp=50", IR_addr); end
    run_instr(itype(6'h2B, 5'd0, 5'd1, 16'd0), 4, 0, '0);
    total++; if (d_seen !== 32'd5) begin bad++; $display("FAIL ill_noreg got=%h exp=5", d_seen); end
    total++; if (Illegal !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%b exp=1", Illegal); end
  endtask

  task automatic test_wrap;
    run_instr(itype(6'h08, 5'd0, 5'd9, 16'hFFFC), 4, 0, '0);
    run_instr(rtype(6'h08, 5'd9, 5'd0, 5'd0), 3, 0, '0);
    total++; if (IR_addr !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_jr got=%h exp=fffffffc", IR_addr); end
    run_instr(itype(6'h08, 5'd0, 5'd0, 16'd9), 4, 0, '0);
    total++; if (IR_addr !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", IR_addr); end
    run_instr(itype(6'h2B, 5'd0, 5'd0, 16'd0), 4, 0, '0);
    total++; if (d_seen !== 32'd0) begin bad++; $display("FAIL reg0 got=%h exp=0", d_seen); end
  endtask

  task automatic test_reset_mid_mem;
    run_instr(itype(6'h2B, 5'd0, 5'd1, 16'd4), 3, 0, '0);
    total++; if (CEN !== 1'b0) begin bad++; $display("FAIL mm_in_mem got=%b exp=0", CEN); end
    total++; if (A !== 7'd1) begin bad++; $display("FAIL mm_a got=%h exp=1", A); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (CEN !== 1'b1) begin bad++; $display("FAIL mm_cen got=%b exp=1", CEN); end
    total++; if (WEN !== 1'b1) begin bad++; $display("FAIL mm_wen got=%b exp=1", WEN); end
    total++; if (IR_addr !== 32'h0) begin bad++; $display("FAIL mm_pc got=%h exp=0", IR_addr); end
    total++; if (Illegal !== 1'b0) begin bad++; $display("FAIL mm_illegal got=%b exp=0", Illegal); end
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(itype(6'h2B, 5'd0, 5'd1, 16'd0), 4, 0, '0);
    total++; if (d_seen !== 32'd0) begin bad++; $display("FAIL mm_rf_clear got=%h exp=0", d_seen); end
    total++; if (IR_addr !== 32'h4) begin bad++; $display("FAIL mm_pc_after got=%h exp=4", IR_addr); end
  endtask

  initial begin
    test_reset();
    test_alu_seq();
    test_sw_wait();
    test_lw();
    test_alu_ops();
    test_branch();
    test_jal_jr();
    test_illegal();
    test_wrap();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
